mult_issue_queue: RTL
=====================

Name: mult_issue_queue

Overview:
- Upstream feeder for the shift-add multiplier.
- Buffers operand pairs arriving on a valid/ready stream and issues them one at a time: one start pulse per pair, with operands held stable for the whole operation.
- Captures the 2*D_SIZE product when the multiplier signals done, and presents it downstream on a valid/ready output.
- Only one multiplication is in flight at a time.

Parameters:
- D_SIZE, 8, operand width; the product is 2*D_SIZE wide.
- DEPTH, 4, operand FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk_in  in  1  single clock; all state updates on the rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept a pair; equals (count < DEPTH).
- in_a  in  D_SIZE  multiplicand.
- in_b  in  D_SIZE  multiplier.
- mul_strt  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  D_SIZE  operand A; held from the strt cycle until done.
- mul_b  out  D_SIZE  operand B; held from the strt cycle until done.
- mul_done  in  1  multiplier result valid, single-cycle pulse.
- mul_product  in  2*D_SIZE  multiplier result; sampled only on mul_done.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts the product.
- out_product  out  2*D_SIZE  captured product.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- err  out  1  sticky flag: mul_done seen while not in WAIT.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state=IDLE; FIFO emptied (count=0, pointers 0).
  - mul_strt=0, mul_a=0, mul_b=0, out_valid=0, out_product=0, err=0.
  - Reset mid-operation drops the in-flight pair and any held result.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready depends only on count, never on a same-cycle pop.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: count unchanged and data order preserved.
  - When full, in_ready=0 and in_valid is ignored.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, count!=0: at the next edge, mul_strt<=1, mul_a/mul_b<=FIFO head, pop, state<=WAIT.
  - IDLE, count==0: remain in IDLE; outputs unchanged.
  - WAIT: mul_strt<=0 after one cycle, so the pulse is exactly one cycle wide.
    - mul_done is ignored in the cycle mul_strt=1.
    - On mul_done: out_product<=mul_product, out_valid<=1, state<=HOLD.
  - HOLD: out_valid and out_product stay stable until out_valid && out_ready.
    - At that edge out_valid<=0 and state<=IDLE.
    - The next pair can be issued no earlier than the following edge.
  - mul_a and mul_b keep their last issued values in IDLE and HOLD.
- Latency:
  - A pair pushed at edge k into an empty, idle block raises mul_strt after edge k+1.
  - out_valid rises at the edge that samples mul_done.
  - Minimum issue-to-issue spacing is the multiplier latency plus 3 cycles when out_ready=1.
- Backpressure: while out_ready=0 in HOLD, no new issue occurs; the FIFO keeps accepting pairs until full.
- err: set when mul_done=1 while state!=WAIT or while mul_strt=1. Cleared only by reset. The stray done is otherwise ignored.
- Width: operands are passed through unmodified, and the product is captured at full 2*D_SIZE with no truncation.

Decomposition:
- Package mult_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, HOLD} issue_state_t.
  - localparam default D_SIZE=8, shared with the multiplier.
- Sub-module mult_operand_fifo:
  - Parameterised by WIDTH (=2*D_SIZE, {a,b} concatenated) and DEPTH.
  - Ports: clk_in, rst_in, push, pop, din, dout (head, combinational read), count.
- The FSM and output registers live in mult_issue_queue.

Test Plan:
All scenarios use D_SIZE=8 and DEPTH=4. The bench multiplier model returns A*B with mul_done pulsed 8 cycles after mul_strt.
- Single op: push (13,11) into an idle block -> mul_strt high for exactly 1 cycle, one edge after the push; mul_a=13 and mul_b=11 stable until done; out_product=0x008F with out_valid=1 until out_ready.
- Burst and ordering: push (3,4), (255,255), (0,7), (1,1) back-to-back, out_ready=1 -> products 0x000C, 0xFE01, 0x0000, 0x0001 in order; exactly one mul_strt per pair; never two in flight.
- Full FIFO: hold out_ready=0 and offer 6 pairs -> first pair issued; count reaches 4; in_ready=0; pairs 6+ not accepted; after release, remaining results appear in order and count drains to 0.
- Simultaneous push/pop: push on the same edge the IDLE FSM pops, with count=2 -> count stays 2, head advances, and the pushed entry is issued later in correct order.
- Stray done: pulse mul_done in IDLE, and again in the mul_strt cycle -> err=1 (sticky); no out_valid; state unaffected.
- Reset mid-op: assert rst_in low during WAIT with 2 pairs queued -> all outputs are 0 immediately (asynchronously); after release, no issue occurs until a new push.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier issue path.
package mult_pkg;

  // Default operand width, shared with the shift-add multiplier.
  localparam int DEF_D_SIZE = 8;

  // Issue FSM: IDLE waits for a queued pair, WAIT covers the multiply,
  // HOLD presents the product until downstream takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } issue_state_t;

endpackage

// File: rtl/mult_operand_fifo.sv
// Operand FIFO: power-of-2 ring buffer with combinational head read.
// Pointers wrap naturally because DEPTH is a power of two.
module mult_operand_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok, pop_ok;

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt state.
  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop  && (count_q != '0);

  // Next-state for pointers and occupancy; push+pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mult_issue_queue.sv
// Issue queue feeding the shift-add multiplier: buffers operand pairs,
// issues one at a time with a single-cycle start pulse, and holds the
// product on a valid/ready output until it is taken.
module mult_issue_queue
  import mult_pkg::*;
#(
  parameter  int D_SIZE = DEF_D_SIZE,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [D_SIZE-1:0]   in_a,
  input  logic [D_SIZE-1:0]   in_b,
  output logic                mul_strt,
  output logic [D_SIZE-1:0]   mul_a,
  output logic [D_SIZE-1:0]   mul_b,
  input  logic                mul_done,
  input  logic [2*D_SIZE-1:0] mul_product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*D_SIZE-1:0] out_product,
  output logic [CW-1:0]       count,
  output logic                err
);

  issue_state_t          state_q, state_d;
  logic                  mul_strt_q, mul_strt_d;
  logic [D_SIZE-1:0]     mul_a_q, mul_a_d;
  logic [D_SIZE-1:0]     mul_b_q, mul_b_d;
  logic                  out_valid_q, out_valid_d;
  logic [2*D_SIZE-1:0]   out_product_q, out_product_d;
  logic                  err_q, err_d;

  logic                  fifo_push, fifo_pop;
  logic [2*D_SIZE-1:0]   fifo_dout;
  logic [CW-1:0]         fifo_count;

  // Acceptance depends on occupancy alone, never on a same-cycle pop.
  assign in_ready  = (fifo_count != CW'(DEPTH));
  assign fifo_push = in_valid && in_ready;

  mult_operand_fifo #(
    .WIDTH (2*D_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    ({in_a, in_b}),
    .dout   (fifo_dout),
    .count  (fifo_count)
  );

  // Issue FSM next-state and output-register next values.
  always_comb begin
    state_d       = state_q;
    mul_strt_d    = 1'b0;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    fifo_pop      = 1'b0;
    // A done outside WAIT, or coinciding with the start pulse, is stray.
    err_d         = err_q | (mul_done & ((state_q != WAIT) | mul_strt_q));
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          mul_strt_d         = 1'b1;
          {mul_a_d, mul_b_d} = fifo_dout;
          fifo_pop           = 1'b1;
          state_d            = WAIT;
        end
      end
      WAIT: begin
        if (mul_done && !mul_strt_q) begin
          out_product_d = mul_product;
          out_valid_d   = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight pair and held result.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      mul_strt_q    <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mul_strt_q    <= mul_strt_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      err_q         <= err_d;
    end
  end

  assign mul_strt    = mul_strt_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign count       = fifo_count;
  assign err         = err_q;

endmodule
